// File: rtl/muldiv_pkg.sv
// -----------------------------------------------------------------------------
// muldiv_pkg
// Shared types for the iterative multiply/divide unit: FSM state encoding,
// operation selector and small helpers for decoding the op strobes.
// No ports (package).
// -----------------------------------------------------------------------------
package muldiv_pkg;

    localparam logic [1:0] ST_IDLE_ENC = 2'd0;
    localparam logic [1:0] ST_CALC_ENC = 2'd1;
    localparam logic [1:0] ST_FIX_ENC  = 2'd2;

    typedef enum logic [1:0] {
        IDLE = ST_IDLE_ENC,
        CALC = ST_CALC_ENC,
        FIX  = ST_FIX_ENC
    } md_state_t;

    typedef enum logic [1:0] {
        MD_MULT,
        MD_MULTU,
        MD_DIV,
        MD_DIVU
    } md_op_t;

    // Priority decode mult > multu > div > divu. divu is the fall-through, so
    // callers only use the result when at least one strobe is asserted.
    function automatic md_op_t select_op(input logic mult, input logic multu,
                                         input logic div);
        if (mult)       return MD_MULT;
        else if (multu) return MD_MULTU;
        else if (div)   return MD_DIV;
        else            return MD_DIVU;
    endfunction

    function automatic logic op_is_signed(input md_op_t op);
        return (op == MD_MULT) || (op == MD_DIV);
    endfunction

    function automatic logic op_is_div(input md_op_t op);
        return (op == MD_DIV) || (op == MD_DIVU);
    endfunction

endpackage

// File: rtl/muldiv_if.sv
// -----------------------------------------------------------------------------
// muldiv_if
// Command/result bundle between the EX stage (master) and muldiv_unit (slave).
//   start, op_mult/op_multu/op_div/op_divu, op_mthi/op_mtlo, abort,
//   src_a, src_b                     : master -> slave
//   busy, done, div0, hi, lo         : slave  -> master
// -----------------------------------------------------------------------------
interface muldiv_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic             op_mult;
    logic             op_multu;
    logic             op_div;
    logic             op_divu;
    logic             op_mthi;
    logic             op_mtlo;
    logic             abort;
    logic [WIDTH-1:0] src_a;
    logic [WIDTH-1:0] src_b;
    logic             busy;
    logic             done;
    logic             div0;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op_mult, op_multu, op_div, op_divu, op_mthi, op_mtlo,
               abort, src_a, src_b,
        input  busy, done, div0, hi, lo
    );

    modport slave (
        input  start, op_mult, op_multu, op_div, op_divu, op_mthi, op_mtlo,
               abort, src_a, src_b,
        output busy, done, div0, hi, lo
    );
endinterface

// File: rtl/muldiv_datapath.sv
// -----------------------------------------------------------------------------
// muldiv_datapath
// 2*WIDTH-bit shift register shared by multiply (shift-add) and divide
// (restoring shift-subtract). Operates on magnitudes only; signs are handled
// by the controller.
//   clk, rst_n : clock, asynchronous active-low reset
//   i_load     : capture |a| into the low half, |b| into the operand register
//   i_step     : perform one radix-2 iteration
//   i_is_div   : 1 = divide step, 0 = multiply step
//   i_a_mag    : multiplicand / dividend magnitude
//   i_b_mag    : multiplier / divisor magnitude
//   o_acc      : {high, low}; mul -> product, div -> {remainder, quotient}
// -----------------------------------------------------------------------------
module muldiv_datapath #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_load,
    input  logic               i_step,
    input  logic               i_is_div,
    input  logic [WIDTH-1:0]   i_a_mag,
    input  logic [WIDTH-1:0]   i_b_mag,
    output logic [2*WIDTH-1:0] o_acc
);

    logic [2*WIDTH-1:0] r_acc;
    logic [WIDTH-1:0]   r_opnd;
    logic [WIDTH:0]     w_mul_sum;
    logic [WIDTH:0]     w_div_diff;
    logic [2*WIDTH-1:0] w_acc_nxt;

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path leaves a latch behind.
        w_acc_nxt  = r_acc;
        // Multiply: the multiplier sits in the low half and is consumed LSB
        // first; the carry of the add becomes the new MSB after the shift.
        w_mul_sum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]} +
                     ({(WIDTH+1){r_acc[0]}} & {1'b0, r_opnd});
        // Divide: trial-subtract from the partial remainder shifted left by
        // one, taken WIDTH+1 bits wide so the bit shifted out is kept.
        w_div_diff = r_acc[2*WIDTH-1:WIDTH-1] - {1'b0, r_opnd};
        if (i_is_div) begin
            if (w_div_diff[WIDTH]) begin
                w_acc_nxt = {r_acc[2*WIDTH-2:0], 1'b0};
            end else begin
                w_acc_nxt = {w_div_diff[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};
            end
        end else begin
            w_acc_nxt = {w_mul_sum, r_acc[WIDTH-1:1]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc  <= '0;
            r_opnd <= '0;
        end else if (i_load) begin
            // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
            r_acc  <= {{WIDTH{1'b0}}, i_a_mag};
            r_opnd <= i_b_mag;
        end else if (i_step) begin
            r_acc  <= w_acc_nxt;
        end
    end

    assign o_acc = r_acc;

endmodule

// File: rtl/muldiv_unit.sv
// -----------------------------------------------------------------------------
// muldiv_unit
// Iterative radix-2 multiply/divide unit owning the HI/LO pair
// (mult, multu, div, divu, mthi, mtlo; mfhi/mflo read hi/lo directly).
// Result lands WIDTH+1 edges after an accepted start.
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : muldiv_if slave (commands in; busy/done/div0/hi/lo out)
// -----------------------------------------------------------------------------
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic     clk,
    input  logic     rst_n,
    muldiv_if.slave  bus
);

    localparam int CNT_W = $clog2(WIDTH) + 1;

    md_state_t          r_state;
    md_state_t          w_state_nxt;
    md_op_t             r_op;
    logic [CNT_W-1:0]   r_cnt;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic               r_done;
    logic               r_div0;
    logic               r_a_neg;
    logic               r_b_neg;
    logic               r_b_zero;
    logic [WIDTH-1:0]   r_src_a;

    logic               w_any_op;
    logic               w_accept;
    md_op_t             w_op_sel;
    logic               w_sel_signed;
    logic               w_a_neg;
    logic               w_b_neg;
    logic [WIDTH-1:0]   w_a_mag;
    logic [WIDTH-1:0]   w_b_mag;
    logic [2*WIDTH-1:0] w_acc;
    logic [2*WIDTH-1:0] w_prod;
    logic [WIDTH-1:0]   w_quo;
    logic [WIDTH-1:0]   w_rem;
    logic [WIDTH-1:0]   w_hi_res;
    logic [WIDTH-1:0]   w_lo_res;
    logic               w_is_div;
    logic               w_commit;

    // Launch decode and magnitude conversion of the incoming operands.
    assign w_any_op     = bus.op_mult | bus.op_multu | bus.op_div | bus.op_divu;
    assign w_accept     = (r_state == IDLE) && bus.start && w_any_op;
    assign w_op_sel     = select_op(bus.op_mult, bus.op_multu, bus.op_div);
    assign w_sel_signed = op_is_signed(w_op_sel);
    assign w_a_neg      = w_sel_signed & bus.src_a[WIDTH-1];
    assign w_b_neg      = w_sel_signed & bus.src_b[WIDTH-1];
    // Negating MIN yields MIN, which is the correct unsigned magnitude.
    assign w_a_mag      = w_a_neg ? -bus.src_a : bus.src_a;
    assign w_b_mag      = w_b_neg ? -bus.src_b : bus.src_b;

    assign w_is_div     = op_is_div(r_op);
    // A FIX cycle that is aborted must not disturb HI/LO or pulse done.
    assign w_commit     = (r_state == FIX) && !bus.abort;

    muldiv_datapath #(.WIDTH(WIDTH)) u_datapath (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_load   (w_accept),
        .i_step   (r_state == CALC),
        .i_is_div (w_is_div),
        .i_a_mag  (w_a_mag),
        .i_b_mag  (w_b_mag),
        .o_acc    (w_acc)
    );

    // Sign fix-up of the magnitude result.
    always_comb begin
        w_prod   = (r_a_neg ^ r_b_neg) ? -w_acc : w_acc;
        w_quo    = w_acc[WIDTH-1:0];
        w_rem    = w_acc[2*WIDTH-1:WIDTH];
        w_hi_res = w_prod[2*WIDTH-1:WIDTH];
        w_lo_res = w_prod[WIDTH-1:0];
        if (r_a_neg ^ r_b_neg) w_quo = -w_acc[WIDTH-1:0];
        // Remainder follows the dividend's sign.
        if (r_a_neg)           w_rem = -w_acc[2*WIDTH-1:WIDTH];
        if (w_is_div) begin
            if (r_b_zero) begin
                w_hi_res = r_src_a;
                w_lo_res = '1;
            end else begin
                w_hi_res = w_rem;
                w_lo_res = w_quo;
            end
        end
    end

    // FSM: state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end

    // FSM: next state.
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            IDLE: if (w_accept) w_state_nxt = CALC;
            CALC: begin
                if (bus.abort)                 w_state_nxt = IDLE;
                else if (r_cnt == CNT_W'(1))   w_state_nxt = FIX;
            end
            FIX:     w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Operation context, iteration counter and the architectural HI/LO pair.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op     <= MD_MULT;
            r_cnt    <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_done   <= 1'b0;
            r_div0   <= 1'b0;
            r_a_neg  <= 1'b0;
            r_b_neg  <= 1'b0;
            r_b_zero <= 1'b0;
            r_src_a  <= '0;
        end else begin
            r_done <= 1'b0;
            r_div0 <= 1'b0;
            if (w_accept) begin
                r_op     <= w_op_sel;
                r_cnt    <= CNT_W'(WIDTH);
                r_a_neg  <= w_a_neg;
                r_b_neg  <= w_b_neg;
                r_b_zero <= (bus.src_b == '0);
                r_src_a  <= bus.src_a;
            end else if (r_state == CALC) begin
                r_cnt    <= r_cnt - 1'b1;
            end

            if (w_commit) begin
                r_hi   <= w_hi_res;
                r_lo   <= w_lo_res;
                r_done <= 1'b1;
                r_div0 <= w_is_div & r_b_zero;
            end else if ((r_state == IDLE) && !bus.start) begin
                if (bus.op_mthi) r_hi <= bus.src_a;
                if (bus.op_mtlo) r_lo <= bus.src_a;
            end
        end
    end

    assign bus.busy = (r_state != IDLE);
    assign bus.done = r_done;
    assign bus.div0 = r_div0;
    assign bus.hi   = r_hi;
    assign bus.lo   = r_lo;

endmodule

// File: tb/tb_muldiv_unit.sv
// -----------------------------------------------------------------------------
// tb_muldiv_unit
// Directed self-checking bench for muldiv_unit (WIDTH = 32): arithmetic
// results, latency, busy length, handshake rules, abort and async reset.
// -----------------------------------------------------------------------------
module tb_muldiv_unit;

    localparam logic [3:0] OP_NONE  = 4'b0000;
    localparam logic [3:0] OP_MULT  = 4'b1000;
    localparam logic [3:0] OP_MULTU = 4'b0100;
    localparam logic [3:0] OP_DIV   = 4'b0010;
    localparam logic [3:0] OP_DIVU  = 4'b0001;
    // Intrusion vector: {start, mult, multu, div, divu, mthi, mtlo}
    localparam logic [6:0] NO_INTR  = 7'b0;

    logic clk;
    logic rst_n;
    int   n_checks = 0;
    int   n_errors = 0;

    muldiv_if #(.WIDTH(32)) bus ();

    muldiv_unit #(.WIDTH(32)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic set_ops(input logic [3:0] ops);
        {bus.op_mult, bus.op_multu, bus.op_div, bus.op_divu} = ops;
    endtask

    // Launch one op, optionally inject extra commands for one cycle after
    // edge 5, then wait (bounded) for done and check result and timing.
    task automatic run_op(input string tag, input logic [3:0] ops,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                          input logic exp_div0, input logic [6:0] intr,
                          input logic [31:0] intr_a, input logic [31:0] intr_b);
        int n;
        int busy_cycles;
        bit seen;
        @(negedge clk);
        bus.start = 1'b1;
        set_ops(ops);
        bus.src_a = a;
        bus.src_b = b;
        @(posedge clk);   // edge 0
        #1;
        bus.start = 1'b0;
        set_ops(OP_NONE);
        n = 0;
        busy_cycles = 0;
        seen = 1'b0;
        while (!seen && n <= 100) begin
            if (n == 5 && intr != NO_INTR) begin
                bus.start   = intr[6];
                set_ops(intr[5:2]);
                bus.op_mthi = intr[1];
                bus.op_mtlo = intr[0];
                bus.src_a   = intr_a;
                bus.src_b   = intr_b;
            end else if (n == 6) begin
                bus.start   = 1'b0;
                set_ops(OP_NONE);
                bus.op_mthi = 1'b0;
                bus.op_mtlo = 1'b0;
            end
            if (bus.busy) busy_cycles++;
            if (bus.done) begin
                seen = 1'b1;
                check({tag, "_hi"},   bus.hi,   exp_hi);
                check({tag, "_lo"},   bus.lo,   exp_lo);
                check({tag, "_div0"}, bus.div0, exp_div0);
            end else begin
                @(posedge clk);
                #1;
                n++;
            end
        end
        check({tag, "_done_seen"}, seen, 1'b1);
        check({tag, "_latency"}, n, 33);
        check({tag, "_busy_cycles"}, busy_cycles, 33);
        @(posedge clk);
        #1;
        check({tag, "_done_one_cycle"}, {bus.done, bus.div0}, 2'b00);
    endtask

    initial begin
        logic [31:0] keep_hi;
        logic [31:0] keep_lo;
        int          done_cnt;

        rst_n     = 1'b0;
        bus.start = 1'b0;
        set_ops(OP_NONE);
        bus.op_mthi = 1'b0;
        bus.op_mtlo = 1'b0;
        bus.abort   = 1'b0;
        bus.src_a   = '0;
        bus.src_b   = '0;
        #23;
        check("rst_busy", bus.busy, 1'b0);
        check("rst_done", bus.done, 1'b0);
        check("rst_div0", bus.div0, 1'b0);
        check("rst_hilo", {bus.hi, bus.lo}, 64'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Multiply
        run_op("multu_max", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
               32'hFFFF_FFFE, 32'h0000_0001, 1'b0, NO_INTR, '0, '0);
        run_op("mult_neg", OP_MULT, 32'hFFFF_FFFE, 32'd3,
               32'hFFFF_FFFF, 32'hFFFF_FFFA, 1'b0, NO_INTR, '0, '0);
        run_op("mult_min", OP_MULT, 32'h8000_0000, 32'h8000_0000,
               32'h4000_0000, 32'h0000_0000, 1'b0, NO_INTR, '0, '0);
        // Priority: mult wins over div
        run_op("prio_mult", OP_MULT | OP_DIV, 32'd6, 32'd7,
               32'd0, 32'd42, 1'b0, NO_INTR, '0, '0);

        // Divide
        run_op("div_neg", OP_DIV, 32'hFFFF_FFF9, 32'd2,
               32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, NO_INTR, '0, '0);
        run_op("div_negb", OP_DIV, 32'd7, 32'hFFFF_FFFE,
               32'd1, 32'hFFFF_FFFD, 1'b0, NO_INTR, '0, '0);
        run_op("divu", OP_DIVU, 32'd7, 32'd2,
               32'd1, 32'd3, 1'b0, NO_INTR, '0, '0);
        run_op("div_min_m1", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF,
               32'd0, 32'h8000_0000, 1'b0, NO_INTR, '0, '0);
        run_op("divu_zero", OP_DIVU, 32'd5, 32'd0,
               32'd5, 32'hFFFF_FFFF, 1'b1, NO_INTR, '0, '0);
        run_op("div_zero_neg", OP_DIV, 32'hFFFF_FFF8, 32'd0,
               32'hFFFF_FFF8, 32'hFFFF_FFFF, 1'b1, NO_INTR, '0, '0);

        // start with no op selected is ignored
        @(negedge clk);
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        check("start_no_op_busy", bus.busy, 1'b0);

        // start (divu) during busy is ignored; mthi during busy is ignored
        run_op("start_in_busy", OP_MULTU, 32'd6, 32'd7,
               32'd0, 32'd42, 1'b0, 7'b1000100, 32'd100, 32'd3);
        run_op("mthi_in_busy", OP_DIVU, 32'd100, 32'd7,
               32'd2, 32'd14, 1'b0, 7'b0000010, 32'h1234, 32'd0);

        // mthi / mtlo in IDLE
        @(negedge clk);
        bus.op_mthi = 1'b1;
        bus.src_a   = 32'h1234;
        @(posedge clk);
        #1;
        bus.op_mthi = 1'b0;
        check("mthi_idle", {bus.hi, bus.lo}, {32'h1234, 32'd14});
        @(negedge clk);
        bus.op_mtlo = 1'b1;
        bus.src_a   = 32'h5678;
        @(posedge clk);
        #1;
        bus.op_mtlo = 1'b0;
        check("mtlo_idle", {bus.hi, bus.lo}, {32'h1234, 32'h5678});

        // abort sampled at edge 10
        keep_hi = 32'h1234;
        keep_lo = 32'h5678;
        @(negedge clk);
        bus.start = 1'b1;
        set_ops(OP_DIVU);
        bus.src_a = 32'd1000;
        bus.src_b = 32'd3;
        @(posedge clk);   // edge 0
        #1;
        bus.start = 1'b0;
        set_ops(OP_NONE);
        repeat (9) @(posedge clk);
        #1;
        check("abort_busy_before", bus.busy, 1'b1);
        bus.abort = 1'b1;
        @(posedge clk);   // edge 10
        #1;
        bus.abort = 1'b0;
        check("abort_busy_after", bus.busy, 1'b0);
        done_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (bus.done) done_cnt++;
        end
        check("abort_no_done", done_cnt, 0);
        check("abort_hilo", {bus.hi, bus.lo}, {keep_hi, keep_lo});

        // Asynchronous reset mid-divide, away from any clock edge
        @(negedge clk);
        bus.start = 1'b1;
        set_ops(OP_DIV);
        bus.src_a = 32'd100;
        bus.src_b = 32'd7;
        @(posedge clk);   // edge 0
        #1;
        bus.start = 1'b0;
        set_ops(OP_NONE);
        repeat (15) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_busy", bus.busy, 1'b0);
        check("async_rst_hilo", {bus.hi, bus.lo}, 64'h0);
        @(negedge clk);
        rst_n = 1'b1;
        run_op("post_rst_multu", OP_MULTU, 32'd3, 32'd4,
               32'd0, 32'd12, 1'b0, NO_INTR, '0, '0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
